// File: rtl/serial_settings_bus_pkg.sv
// Shared constants, state encoding and helpers for the serial settings-bus receiver.
package serial_settings_pkg;

  localparam int FRAME_BITS = 40;
  localparam int HDR_BITS   = 8;
  localparam int SET_ADDR_W = 7;
  localparam int SET_DATA_W = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    WR_DATA = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  // Bit counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

endpackage

// File: rtl/serial_settings_bus_if.sv
// Parallel settings bus: write strobe, address, data and the externally selected read-back word.
interface serial_settings_bus_if;
  import serial_settings_pkg::*;

  logic                  strobe;
  logic [SET_ADDR_W-1:0] addr;
  logic [SET_DATA_W-1:0] data;
  logic [SET_DATA_W-1:0] readback_data;

  modport master (output strobe, output addr, output data, input readback_data);
  modport slave  (input strobe, input addr, input data, output readback_data);

endinterface

// File: rtl/serial_settings_bus_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, plus an edge register that
// produces aligned level / rise / fall outputs SYNC_STAGES+1 cycles after the pin.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   rise_r;
  logic                   fall_r;

  // Synchronizer chain, free-running so it keeps tracking the pin through reset.
  always_ff @(posedge clock) begin
    sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
  end

  // Edge register; it follows the pin during reset so a level held across reset is never an edge.
  always_ff @(posedge clock) begin
    prev_r <= sync_r[SYNC_STAGES-1];
    if (reset) begin
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      rise_r <= sync_r[SYNC_STAGES-1] & ~prev_r;
      fall_r <= ~sync_r[SYNC_STAGES-1] & prev_r;
    end
  end

  assign level = prev_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/serial_settings_bus.sv
// 3-wire serial control port receiver: deserializes host frames onto the settings bus
// and shifts read-back words out on serial_dout, all in the master clock domain.
module serial_settings_bus
  import serial_settings_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = serial_settings_pkg::FRAME_BITS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         serial_enable,
  input  logic                         serial_clk,
  input  logic                         serial_din,
  output logic                         serial_dout,
  output logic                         serial_dout_oe,
  output logic                         frame_error,
  serial_settings_bus_if.master        bus
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] HDR_LAST   = CNT_W'(HDR_BITS - 1);

  logic en_level_unused_s, en_rise_s, en_fall_s;
  logic clk_level_unused_s, clk_rise_s, clk_fall_s;
  logic din_level_s, din_rise_unused_s, din_fall_unused_s;

  state_t                state_r;
  logic [CNT_W-1:0]      count_r;
  logic [FRAME_BITS-2:0] shift_r;
  logic [FRAME_BITS-2:0] shift_next_s;
  logic [SET_DATA_W-1:0] rd_shift_r;
  logic                  rd_load_r;
  logic                  strobe_r;
  logic [SET_ADDR_W-1:0] addr_r;
  logic [SET_DATA_W-1:0] data_r;
  logic                  dout_r;
  logic                  dout_oe_r;
  logic                  frame_error_r;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_en (
    .clock(clock), .reset(reset), .async_in(serial_enable),
    .level(en_level_unused_s), .rise(en_rise_s), .fall(en_fall_s)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clock(clock), .reset(reset), .async_in(serial_clk),
    .level(clk_level_unused_s), .rise(clk_rise_s), .fall(clk_fall_s)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
    .clock(clock), .reset(reset), .async_in(serial_din),
    .level(din_level_s), .rise(din_rise_unused_s), .fall(din_fall_unused_s)
  );

  // The R/W bit drops out of the 39-bit window once the full frame is in; only addr+data remain.
  assign shift_next_s = {shift_r[FRAME_BITS-3:0], din_level_s};

  // Frame sequencing, bit counting and all registered outputs; enable fall has priority over clk edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      count_r       <= '0;
      shift_r       <= '0;
      rd_shift_r    <= '0;
      rd_load_r     <= 1'b0;
      strobe_r      <= 1'b0;
      addr_r        <= '0;
      data_r        <= '0;
      dout_r        <= 1'b0;
      dout_oe_r     <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      strobe_r      <= 1'b0;
      frame_error_r <= 1'b0;
      if (en_fall_s) begin
        state_r   <= IDLE;
        dout_r    <= 1'b0;
        dout_oe_r <= 1'b0;
        rd_load_r <= 1'b0;
        case (state_r)
          WR_DATA: begin
            if (count_r == FULL_COUNT) begin
              addr_r   <= shift_r[SET_DATA_W +: SET_ADDR_W];
              data_r   <= shift_r[SET_DATA_W-1:0];
              strobe_r <= 1'b1;
            end else begin
              frame_error_r <= 1'b1;
            end
          end
          RD_DATA: frame_error_r <= (count_r != FULL_COUNT);
          HDR:     frame_error_r <= 1'b1;
          default: ;
        endcase
      end else begin
        case (state_r)
          IDLE: begin
            if (en_rise_s) begin
              state_r <= HDR;
              count_r <= '0;
              shift_r <= '0;
            end
          end
          HDR: begin
            if (clk_rise_s) begin
              shift_r <= shift_next_s;
              count_r <= sat_inc(count_r);
              if (count_r == HDR_LAST) begin
                if (shift_next_s[HDR_BITS-1]) begin
                  state_r   <= RD_DATA;
                  addr_r    <= shift_next_s[SET_ADDR_W-1:0];
                  rd_load_r <= 1'b1;
                  dout_oe_r <= 1'b1;
                end else begin
                  state_r <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (clk_rise_s) begin
              shift_r <= shift_next_s;
              count_r <= sat_inc(count_r);
            end
          end
          RD_DATA: begin
            if (clk_rise_s) begin
              count_r <= sat_inc(count_r);
            end
            // Read-back word is sampled one cycle after addr settles, well before the first falling edge.
            if (rd_load_r) begin
              rd_shift_r <= bus.readback_data;
              rd_load_r  <= 1'b0;
            end else if (clk_fall_s) begin
              dout_r     <= rd_shift_r[SET_DATA_W-1];
              rd_shift_r <= {rd_shift_r[SET_DATA_W-2:0], 1'b0};
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign serial_dout    = dout_r;
  assign serial_dout_oe = dout_oe_r;
  assign frame_error    = frame_error_r;
  assign bus.strobe     = strobe_r;
  assign bus.addr       = addr_r;
  assign bus.data       = data_r;

endmodule

// File: doc/serial_settings_bus.md
# serial_settings_bus

Clock-domain receiver for the 3-wire serial control port. It deserializes host frames into the parallel settings bus (strobe, addr[6:0], data[31:0]) that drives every `setting_reg` and `setting_reg_masked` instance. It also serves read-back frames by shifting a 32-bit word out on the serial data line. It sits between the board-level serial pins and the settings registers, entirely in the master `clock` domain.

## Interface
- SYNC_STAGES, 2, synchronizer flops on each asynchronous serial input (>= 2)
- FRAME_BITS, 40, fixed frame length: 1 R/W bit + 7 addr bits + 32 data bits
- clock  input  1  master clock
- reset  input  1  synchronous, active-high
- serial_enable  input  1  asynchronous; high frames a transaction
- serial_clk  input  1  asynchronous; data sampled on its rising edge
- serial_din  input  1  asynchronous; MSB-first frame data
- serial_dout  output  1  read-back data, changes after serial_clk falling edge
- serial_dout_oe  output  1  high while a read frame is shifting data out
- strobe  output  1  one-cycle write pulse to settings registers
- addr  output  7  settings address; valid with strobe, and during read frames
- data  output  32  write value; valid with strobe, held until next write
- readback_data  input  32  word selected externally by addr, sampled on read
- frame_error  output  1  one-cycle pulse on malformed frame

## Operation
- Frame bit order, MSB first: bit 0 is R/W (1 = read), bits 1–7 are addr[6:0], bits 8–39 are the data word.
- All three serial inputs pass through SYNC_STAGES flops plus one edge register. Edges are detected SYNC_STAGES+1 cycles after the pin changes.
- Bit counter is 6 bits wide, saturating at 63. It is cleared when serial_enable rises and incremented on each detected serial_clk rising edge.
- State machine:
  - IDLE → HDR on enable rise.
  - HDR: shift in 8 bits. After the 8th bit, the R/W bit selects the next state.
    - R/W = 0 → WR_DATA.
    - R/W = 1 → RD_DATA. addr is loaded with the header address. readback_data is captured into the output shift register one cycle later.
  - WR_DATA: shift 32 bits into an internal register. addr and data outputs do not change.
  - RD_DATA: serial_dout_oe = 1. On each serial_clk falling edge, the next bit is driven, starting with readback_data[31] after the falling edge that follows bit 7. Incoming din is ignored.
  - Any state → IDLE on enable fall.
- Enable fall from WR_DATA with count == 40: load addr and data from the shift register, then pulse strobe for 1 cycle.
- Enable fall from WR_DATA with count != 40, or from HDR: no strobe; pulse frame_error for 1 cycle. The same applies to enable fall from RD_DATA with count != 40.
- Read frames never assert strobe.

## Timing
- Reset values: strobe = 0, addr = 0, data = 0, serial_dout = 0, serial_dout_oe = 0, frame_error = 0, state = IDLE, counter = 0.
- Reset mid-frame: return to IDLE, discard the partial frame. A new frame starts only after enable is synchronized low and then rises again; enable already high when reset releases is ignored.
- strobe asserts SYNC_STAGES+2 cycles after the serial_enable pin falls (4 cycles at default), for exactly one cycle. addr and data are stable that same cycle and held afterwards.
- Host constraint: serial_clk high and low phases are each >= SYNC_STAGES+2 clock cycles. Enable low between frames is >= SYNC_STAGES+2 cycles. Faster input is out of spec, with no required behaviour.
- serial_dout_oe falls in the cycle enable fall is detected.
- Simultaneous enable fall and serial_clk rise in the same detection cycle: enable fall wins, and the clk edge is not counted.

## Structure
- Shared package `serial_settings_pkg`:
  - Constants: FRAME_BITS = 40, HDR_BITS = 8, SET_ADDR_W = 7, SET_DATA_W = 32.
  - State encoding: IDLE, HDR, WR_DATA, RD_DATA.
- One sub-module, `sync_edge_detect`:
  - SYNC_STAGES synchronizer plus edge register.
  - Outputs: level, rise, fall.
  - Instantiated for serial_enable and serial_clk. serial_din uses its level output only.

## Test plan
- Write frame R/W=0, addr 0x05, data 0xFFFF_00A5, serial_clk at clock/10 → exactly one strobe 4 cycles after enable falls, with addr = 0x05 and data = 0xFFFF00A5; frame_error stays 0.
- Read frame addr 0x12, readback_data = 0xDEADBEEF → addr = 0x12 after bit 7, serial_dout_oe high, 0xDEADBEEF shifted MSB first on falling edges, no strobe.
- Truncated write (39 clocks) and overlong write (41 clocks) → frame_error pulse each, no strobe, addr/data keep prior values.
- Reset asserted after 20 bits, released with enable still high → all outputs 0, remaining bits ignored, no strobe. The next full write frame addr 0x7F, data 0x00000001 strobes correctly.
- Back-to-back writes with enable low for exactly 4 cycles between them → two strobes carrying the respective addr/data, no errors.
- Enable fall coincident with the 40th serial_clk rise → frame_error, no strobe.
